compare_pipe: RTL and testbench

Parametrised, pipelined successor to the team's 1-bit equality comparator. Compares two WIDTH-bit operands per valid sample, signed or unsigned. Produces equal/less/greater flags plus a mode-selected "hit" result, 2 cycles after input. Optionally keeps running statistics and a consecutive-miss alarm. Sits between a sample source and a monitor/scoreboard in the lab designs driven by the common clock.

---
 rtl/compare_pipe.sv | 142 ++++++++++++++
 tb/tb_compare_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/compare_pipe.sv
// compare_pipe: two-stage pipelined WIDTH-bit comparator with signed/unsigned
// select, equal/less/greater flags and a mode-selected hit result.
// Optional statistics (sample/hit counters, consecutive-miss alarm) are built
// only when CMP_STATS_EN is defined; otherwise they are tied to zero and
// clear is ignored.
module compare_pipe #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 16,
  parameter int STREAK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             is_signed,
  output logic             out_valid,
  output logic             equal,
  output logic             less,
  output logic             greater,
  output logic             hit,
  output logic             streak_alarm,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] sample_count
);

  logic             v1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       mode1;
  logic             sgn1;

  logic [WIDTH-1:0] ka;
  logic [WIDTH-1:0] kb;
  logic             eq_c;
  logic             lt_c;
  logic             gt_c;
  logic             hit_c;

  // Stage 1: capture the sample unconditionally; only the valid bit matters downstream
  always_ff @(posedge clock) begin
    if (reset) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      mode1 <= 2'b00;
      sgn1  <= 1'b0;
    end else begin
      v1    <= in_valid;
      a1    <= a;
      b1    <= b;
      mode1 <= mode;
      sgn1  <= is_signed;
    end
  end

  // Compare: inverting the sign bit maps two's-complement order onto unsigned order
  always_comb begin
    ka = a1;
    kb = b1;
    if (sgn1) begin
      ka[WIDTH-1] = ~a1[WIDTH-1];
      kb[WIDTH-1] = ~b1[WIDTH-1];
    end
    eq_c = (a1 == b1);
    lt_c = (ka < kb);
    gt_c = (ka > kb);
    case (mode1)
      2'b00:   hit_c = eq_c;
      2'b01:   hit_c = lt_c;
      2'b10:   hit_c = gt_c;
      default: hit_c = ~eq_c;
    endcase
  end

  // Stage 2: register result flags; they hold their last value on idle cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      equal     <= 1'b0;
      less      <= 1'b0;
      greater   <= 1'b0;
      hit       <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        equal   <= eq_c;
        less    <= lt_c;
        greater <= gt_c;
        hit     <= hit_c;
      end
    end
  end

`ifdef CMP_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] STREAK_C = CNT_W'(STREAK);

  logic [CNT_W-1:0] miss_count;
  logic [CNT_W-1:0] miss_next;

  // Saturating increment of the consecutive-miss counter
  always_comb begin
    miss_next = (miss_count == CNT_MAX) ? miss_count : miss_count + 1'b1;
  end

  // Statistics update on the same edge that publishes a valid result; clear beats it
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      sample_count <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      streak_alarm <= 1'b0;
    end else if (v1) begin
      if (sample_count != CNT_MAX) begin
        sample_count <= sample_count + 1'b1;
      end
      if (hit_c) begin
        if (hit_count != CNT_MAX) begin
          hit_count <= hit_count + 1'b1;
        end
        miss_count <= '0;
      end else begin
        miss_count <= miss_next;
        if (miss_next == STREAK_C) begin
          streak_alarm <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_clear;

  assign unused_clear = clear;
  assign hit_count    = '0;
  assign sample_count = '0;
  assign streak_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_compare_pipe.sv
// Directed bench for compare_pipe: reset/latency, signed vs unsigned, a
// pseudo-random stream against a behavioural model, streak alarm, clear
// collision, counter saturation and WIDTH=1 signed ordering.
module tb_compare_pipe;

`ifdef CMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  mode;
  logic        is_signed;
  logic        out_valid, equal, less, greater, hit, streak_alarm;
  logic [15:0] hit_count, sample_count;

  logic        s_clear, s_in_valid, s_a, s_b, s_is_signed;
  logic [1:0]  s_mode;
  logic        s_out_valid, s_equal, s_less, s_greater, s_hit, s_streak_alarm;
  logic [1:0]  s_hit_count, s_sample_count;

  int errors = 0;
  int checks = 0;

  compare_pipe #(.WIDTH(8), .CNT_W(16), .STREAK(4)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .mode(mode), .is_signed(is_signed),
    .out_valid(out_valid), .equal(equal), .less(less), .greater(greater),
    .hit(hit), .streak_alarm(streak_alarm), .hit_count(hit_count),
    .sample_count(sample_count)
  );

  compare_pipe #(.WIDTH(1), .CNT_W(2), .STREAK(2)) dut_sat (
    .clock(clock), .reset(reset), .clear(s_clear), .in_valid(s_in_valid),
    .a(s_a), .b(s_b), .mode(s_mode), .is_signed(s_is_signed),
    .out_valid(s_out_valid), .equal(s_equal), .less(s_less), .greater(s_greater),
    .hit(s_hit), .streak_alarm(s_streak_alarm), .hit_count(s_hit_count),
    .sample_count(s_sample_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y,
                       input logic [1:0] m, input logic s);
    in_valid  = v;
    a         = x;
    b         = y;
    mode      = m;
    is_signed = s;
  endtask

  function automatic logic [31:0] cexp(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  // Reference compare written with native signed arithmetic; returns {eq,lt,gt,hit}
  function automatic logic [3:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic [1:0] m, input logic s);
    logic e, l, g, h;
    e = (x == y);
    if (s) begin
      l = ($signed(x) < $signed(y));
      g = ($signed(x) > $signed(y));
    end else begin
      l = (x < y);
      g = (x > y);
    end
    case (m)
      2'd0:    h = e;
      2'd1:    h = l;
      2'd2:    h = g;
      default: h = ~e;
    endcase
    return {e, l, g, h};
  endfunction

  logic [7:0] va [7];
  logic [7:0] vb [7];
  logic [1:0] vm [7];
  logic       vs [7];
  logic [3:0] ve [7];
  logic [7:0] ra [100];
  logic [7:0] rb [100];
  logic [1:0] rm [100];
  logic       rs [100];
  int         rhits;

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    drive(1'b1, 8'h12, 8'h12, 2'b00, 1'b0);
    s_clear = 1'b0; s_in_valid = 1'b0; s_a = 1'b0; s_b = 1'b0;
    s_mode = 2'b00; s_is_signed = 1'b0;

    // Reset held 3 cycles with a valid sample present: everything stays 0
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_flags", 32'({out_valid, equal, less, greater, hit, streak_alarm}), 32'd0);
      check("rst_counts", 32'({hit_count, sample_count}), 32'd0);
    end

    // First sample right after reset: result exactly 2 edges later
    reset = 1'b0;
    drive(1'b1, 8'h12, 8'h12, 2'b00, 1'b0);
    tick();
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    tick();
    check("lat_edge2_result", 32'({out_valid, equal, less, greater, hit}), 32'b11001);
    check("lat_sample_count", 32'(sample_count), cexp(1));
    check("lat_hit_count", 32'(hit_count), cexp(1));

    // Directed vectors, back-to-back; expected {eq,lt,gt,hit} hand-computed
    va[0] = 8'hF0; vb[0] = 8'h10; vm[0] = 2'b01; vs[0] = 1'b0; ve[0] = 4'b0010;
    va[1] = 8'hF0; vb[1] = 8'h10; vm[1] = 2'b01; vs[1] = 1'b1; ve[1] = 4'b0101;
    va[2] = 8'h80; vb[2] = 8'h7F; vm[2] = 2'b10; vs[2] = 1'b1; ve[2] = 4'b0100;
    va[3] = 8'h80; vb[3] = 8'h7F; vm[3] = 2'b10; vs[3] = 1'b0; ve[3] = 4'b0011;
    va[4] = 8'h05; vb[4] = 8'h05; vm[4] = 2'b11; vs[4] = 1'b0; ve[4] = 4'b1000;
    va[5] = 8'hFF; vb[5] = 8'h00; vm[5] = 2'b11; vs[5] = 1'b1; ve[5] = 4'b0101;
    va[6] = 8'h00; vb[6] = 8'hFF; vm[6] = 2'b00; vs[6] = 1'b1; ve[6] = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) drive(1'b1, va[i], vb[i], vm[i], vs[i]);
      else       drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
      tick();
      if (i >= 1) begin
        check($sformatf("dir_vec%0d", i - 1),
              32'({out_valid, equal, less, greater, hit}), 32'({1'b1, ve[i - 1]}));
      end
    end
    tick();
    check("idle_hold", 32'({out_valid, equal, less, greater, hit}), 32'b00010);

    // Back-to-back pseudo-random stream against the model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rhits = 0;
    for (int i = 0; i < 101; i++) begin
      if (i < 100) begin
        ra[i] = 8'($urandom);
        rb[i] = (i % 7 == 0) ? ra[i] : 8'($urandom);
        rm[i] = 2'($urandom);
        rs[i] = 1'($urandom);
        if (model(ra[i], rb[i], rm[i], rs[i]) & 4'b0001) rhits++;
        drive(1'b1, ra[i], rb[i], rm[i], rs[i]);
      end else begin
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
      end
      tick();
      if (i >= 1) begin
        check($sformatf("stream%0d", i - 1),
              32'({out_valid, equal, less, greater, hit}),
              32'({1'b1, model(ra[i - 1], rb[i - 1], rm[i - 1], rs[i - 1])}));
      end
    end
    tick();
    check("stream_sample_count", 32'(sample_count), cexp(100));
    check("stream_hit_count", 32'(hit_count), cexp(rhits));

    // Streak: miss, miss, miss, hit, then 4 misses -> alarm on the 8th result
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, (i == 3) ? 8'h33 : 8'h40, 8'h33, 2'b00, 1'b0);
      else       drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
      tick();
      if (i >= 1) begin
        check($sformatf("streak_res%0d", i - 1), 32'(streak_alarm), cexp((i == 8) ? 1 : 0));
      end
    end
    tick();
    tick();
    check("streak_sticky", 32'(streak_alarm), cexp(1));
    check("streak_hit_count", 32'(hit_count), cexp(1));
    check("streak_sample_count", 32'(sample_count), cexp(8));

    // Clear collides with a completing hit result: clear wins, result still shown
    drive(1'b1, 8'h55, 8'h55, 2'b00, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_result", 32'({out_valid, hit}), 32'b11);
    check("clr_counts", 32'({hit_count, sample_count}), 32'd0);
    check("clr_alarm", 32'(streak_alarm), 32'd0);
    tick();
    check("clr_after", 32'({out_valid, hit_count, sample_count}), 32'd0);

    // Saturation on the CNT_W=2 instance: 6 hits, counters stop at 3
    for (int i = 0; i < 7; i++) begin
      s_in_valid = (i < 6); s_a = 1'b1; s_b = 1'b1; s_mode = 2'b00; s_is_signed = 1'b0;
      tick();
      if (i >= 1) begin
        check($sformatf("sat_sample%0d", i), 32'(s_sample_count), cexp((i > 3) ? 3 : i));
        check($sformatf("sat_hit%0d", i), 32'(s_hit_count), cexp((i > 3) ? 3 : i));
      end
    end

    // WIDTH=1 signed: 1 is -1, so 1 < 0 signed but 1 > 0 unsigned
    s_in_valid = 1'b1; s_a = 1'b1; s_b = 1'b0; s_mode = 2'b01; s_is_signed = 1'b1;
    tick();
    s_is_signed = 1'b0;
    tick();
    s_in_valid = 1'b0;
    check("w1_signed", 32'({s_out_valid, s_equal, s_less, s_greater, s_hit}), 32'b10101);
    tick();
    check("w1_unsigned", 32'({s_out_valid, s_equal, s_less, s_greater, s_hit}), 32'b10010);
    check("w1_alarm", 32'(s_streak_alarm), 32'd0);
    check("w1_sat_sample", 32'(s_sample_count), cexp(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
